// File: rtl/rf_pkg.sv
// Shared register-file package.
// Holds the data and address width defaults that the ALU and the CPU top
// also use. It also holds the hardwired zero-register address and a helper
// that locates one port's field inside a packed multi-port bus.
package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int ZERO_ADDR = 0;

  // Returns the lowest bit of port 'port' in a bus made of 'width'-bit
  // fields packed side by side (port 0 in the least significant field).
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_scoreboard_if.sv
// Bus between decode/writeback and the scoreboarded register file.
// Ports (all interface signals):
//   RD_ADDR  packed read addresses, port k in [k*ADDR_W +: ADDR_W]
//   RD_DATA  packed read data, same packing
//   RD_BUSY  per-port busy flag of the addressed register
//   WR_EN / WR_ADDR / WR_DATA  writeback port
//   ISS_EN / ISS_ADDR          issue port (marks a destination pending)
// Modports: master = pipeline side, slave = register file.
interface rf_scoreboard_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2
);

  logic [NUM_READ*ADDR_W-1:0] RD_ADDR;
  logic [NUM_READ*DATA_W-1:0] RD_DATA;
  logic [NUM_READ-1:0]        RD_BUSY;
  logic                       WR_EN;
  logic [ADDR_W-1:0]          WR_ADDR;
  logic [DATA_W-1:0]          WR_DATA;
  logic                       ISS_EN;
  logic [ADDR_W-1:0]          ISS_ADDR;

  modport master (
    output RD_ADDR, WR_EN, WR_ADDR, WR_DATA, ISS_EN, ISS_ADDR,
    input  RD_DATA, RD_BUSY
  );

  modport slave (
    input  RD_ADDR, WR_EN, WR_ADDR, WR_DATA, ISS_EN, ISS_ADDR,
    output RD_DATA, RD_BUSY
  );

endinterface

// File: rtl/rf_read_port.sv
// Single combinational read port of the scoreboarded register file.
// It applies this priority to one address:
// zero register first, then the write bypass, then the stored array entry.
// Ports:
//   rd_addr   address being read
//   wr_en     writeback enable, already gated off while the file is in reset
//   wr_addr   writeback address
//   wr_data   writeback data
//   arr_data  stored value of reg[rd_addr]
//   arr_busy  stored busy bit of reg[rd_addr]
//   rd_data   resulting read data
//   rd_busy   resulting busy flag
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              arr_busy,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_busy
);

  logic is_zero;
  logic is_bypass;

  assign is_zero   = ZERO_REG && (rd_addr == ADDR_W'(ZERO_ADDR));
  assign is_bypass = BYPASS && wr_en && (wr_addr == rd_addr);

  // A forwarded write always reports not-busy because the write itself
  // clears the busy bit. A same-cycle issue only shows from the next cycle,
  // so it does not take part here.
  always_comb begin
    rd_data = arr_data;
    rd_busy = arr_busy;
    if (is_zero) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end else if (is_bypass) begin
      rd_data = wr_data;
      rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/rf_scoreboard.sv
// Parametrised register file with per-register busy (scoreboard) bits.
// Decode reads operands and issues destinations; writeback writes results.
// Ports:
//   CLK, RESET      clock (rising edge) and asynchronous active-high reset
//   bus             rf_scoreboard_if slave: read, write and issue ports
//   BUSY_CNT        registered count of busy registers (popcount of busy)
//   TEST_R0..R3     raw stored contents of registers 0..3, never bypassed
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_READ = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  rf_scoreboard_if.slave    bus,
  output logic [ADDR_W:0]   BUSY_CNT,
  output logic [DATA_W-1:0] TEST_R0,
  output logic [DATA_W-1:0] TEST_R1,
  output logic [DATA_W-1:0] TEST_R2,
  output logic [DATA_W-1:0] TEST_R3
);

  localparam int DEPTH = 2 ** ADDR_W;

  if (NUM_READ < 1 || NUM_READ > 4) begin : g_bad_num_read
    $error("rf_scoreboard: NUM_READ must be in 1..4");
  end
  if (ADDR_W < 2) begin : g_bad_addr_w
    $error("rf_scoreboard: ADDR_W must be at least 2 for the debug taps");
  end

  logic [DATA_W-1:0] reg_q [DEPTH];
  logic [DATA_W-1:0] reg_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [ADDR_W:0]   busy_cnt_q;
  logic [ADDR_W:0]   busy_cnt_d;

  logic wr_ok;
  logic iss_ok;
  logic cnt_inc;
  logic cnt_dec;
  logic byp_wr_en;

  // Writes and issues aimed at the hardwired zero register are dropped.
  assign wr_ok  = bus.WR_EN  && !(ZERO_REG && bus.WR_ADDR  == ADDR_W'(ZERO_ADDR));
  assign iss_ok = bus.ISS_EN && !(ZERO_REG && bus.ISS_ADDR == ADDR_W'(ZERO_ADDR));

  // The flops clear through the async reset. The bypass path is
  // combinational, so it is gated off here to keep reads at 0 during reset.
  assign byp_wr_en = bus.WR_EN && !RESET;

  // Next state of the data array and busy vector. The issue is applied after
  // the write, so a same-address issue leaves the register busy: the newer
  // producer wins.
  always_comb begin
    reg_d  = reg_q;
    busy_d = busy_q;
    if (wr_ok) begin
      reg_d[bus.WR_ADDR]  = bus.WR_DATA;
      busy_d[bus.WR_ADDR] = 1'b0;
    end
    if (iss_ok) begin
      busy_d[bus.ISS_ADDR] = 1'b1;
    end
  end

  // The count tracks the popcount of the busy vector incrementally.
  // An issue adds one only when it sets a clear bit. A write removes one only
  // when it clears a set bit that the same-cycle issue does not set again.
  always_comb begin
    cnt_inc    = iss_ok && !busy_q[bus.ISS_ADDR];
    cnt_dec    = wr_ok && busy_q[bus.WR_ADDR] &&
                 !(iss_ok && bus.ISS_ADDR == bus.WR_ADDR);
    busy_cnt_d = busy_cnt_q + {{ADDR_W{1'b0}}, cnt_inc}
                            - {{ADDR_W{1'b0}}, cnt_dec};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      reg_q      <= reg_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  logic [NUM_READ-1:0][DATA_W-1:0] rd_data_arr;
  logic [NUM_READ-1:0]             rd_busy_arr;

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = bus.RD_ADDR[port_lsb(k, ADDR_W) +: ADDR_W];

    rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_port (
      .rd_addr  (addr),
      .wr_en    (byp_wr_en),
      .wr_addr  (bus.WR_ADDR),
      .wr_data  (bus.WR_DATA),
      .arr_data (reg_q[addr]),
      .arr_busy (busy_q[addr]),
      .rd_data  (rd_data_arr[k]),
      .rd_busy  (rd_busy_arr[k])
    );
  end

  assign bus.RD_DATA = rd_data_arr;
  assign bus.RD_BUSY = rd_busy_arr;

  assign BUSY_CNT = busy_cnt_q;
  assign TEST_R0  = reg_q[0];
  assign TEST_R1  = reg_q[1];
  assign TEST_R2  = reg_q[2];
  assign TEST_R3  = reg_q[3];

endmodule

// File: tb/tb_rf_scoreboard.sv
// Testbench for rf_scoreboard.
// Two copies of the file see the same stimulus: dut with the bypass
// enabled and dut_nb with BYPASS=0. A table of single-cycle vectors covers
// reads, writes, issues and the zero register. Hand-written sequences cover
// the bypass-off behaviour, saturation of the busy count and an
// asynchronous reset asserted mid-cycle.
module tb_rf_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic CLK;
  logic RESET;

  rf_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR)) bus_a ();
  rf_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR)) bus_b ();

  logic [AW:0]   busy_cnt, busy_cnt_nb;
  logic [DW-1:0] t0, t1, t2, t3, nb0, nb1, nb2, nb3;

  assign bus_b.RD_ADDR  = bus_a.RD_ADDR;
  assign bus_b.WR_EN    = bus_a.WR_EN;
  assign bus_b.WR_ADDR  = bus_a.WR_ADDR;
  assign bus_b.WR_DATA  = bus_a.WR_DATA;
  assign bus_b.ISS_EN   = bus_a.ISS_EN;
  assign bus_b.ISS_ADDR = bus_a.ISS_ADDR;

  rf_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus_a.slave), .BUSY_CNT(busy_cnt),
    .TEST_R0(t0), .TEST_R1(t1), .TEST_R2(t2), .TEST_R3(t3)
  );

  rf_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
    .CLK(CLK), .RESET(RESET), .bus(bus_b.slave), .BUSY_CNT(busy_cnt_nb),
    .TEST_R0(nb0), .TEST_R1(nb1), .TEST_R2(nb2), .TEST_R3(nb3)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          iss_en;
    logic [AW-1:0] iss_addr;
    logic [AW-1:0] rd0;
    logic [AW-1:0] rd1;
    logic [DW-1:0] exp_d0;
    logic          exp_b0;
    logic [DW-1:0] exp_d1;
    logic          exp_b1;
    logic [AW:0]   exp_cnt;
  } vec_t;

  vec_t vecs[13];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic ie, input logic [AW-1:0] ia,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    bus_a.WR_EN    = we;
    bus_a.WR_ADDR  = wa;
    bus_a.WR_DATA  = wd;
    bus_a.ISS_EN   = ie;
    bus_a.ISS_ADDR = ia;
    bus_a.RD_ADDR  = {r1, r0};
  endtask

  task automatic applyStimulus(input vec_t v);
    drive(v.wr_en, v.wr_addr, v.wr_data, v.iss_en, v.iss_addr, v.rd0, v.rd1);
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    check($sformatf("v%0d_data0", idx), 64'(bus_a.RD_DATA[DW-1:0]), 64'(v.exp_d0));
    check($sformatf("v%0d_busy0", idx), 64'(bus_a.RD_BUSY[0]), 64'(v.exp_b0));
    check($sformatf("v%0d_data1", idx), 64'(bus_a.RD_DATA[2*DW-1:DW]), 64'(v.exp_d1));
    check($sformatf("v%0d_busy1", idx), 64'(bus_a.RD_BUSY[1]), 64'(v.exp_b1));
    check($sformatf("v%0d_cnt", idx), 64'(busy_cnt), 64'(v.exp_cnt));
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Each row lists: write, issue, two read addresses, then the expected
    // read data/busy per port and the busy count before the edge.
    vecs[0]  = '{1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0,  5'd3, 5'd0, 32'h12345678, 1'b0, 32'h0,        1'b0, 6'd0};
    vecs[1]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0,  5'd3, 5'd0, 32'h12345678, 1'b0, 32'h0,        1'b0, 6'd0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9,  5'd9, 5'd3, 32'h0,        1'b0, 32'h12345678, 1'b0, 6'd0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  5'd9, 5'd0, 32'h0,        1'b1, 32'h0,        1'b0, 6'd1};
    vecs[4]  = '{1'b1, 5'd9, 32'h55,       1'b0, 5'd0,  5'd9, 5'd3, 32'h55,       1'b0, 32'h12345678, 1'b0, 6'd1};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4,  5'd9, 5'd4, 32'h55,       1'b0, 32'h0,        1'b0, 6'd0};
    vecs[6]  = '{1'b1, 5'd4, 32'h77,       1'b1, 5'd4,  5'd4, 5'd9, 32'h77,       1'b0, 32'h55,       1'b0, 6'd1};
    vecs[7]  = '{1'b1, 5'd4, 32'h88,       1'b1, 5'd6,  5'd4, 5'd6, 32'h88,       1'b0, 32'h0,        1'b0, 6'd1};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  5'd4, 5'd6, 32'h88,       1'b0, 32'h0,        1'b1, 6'd1};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0,  5'd0, 5'd6, 32'h0,        1'b0, 32'h0,        1'b1, 6'd1};
    vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  5'd0, 5'd6, 32'h0,        1'b0, 32'h0,        1'b1, 6'd1};
    vecs[11] = '{1'b1, 5'd6, 32'h66,       1'b1, 5'd0,  5'd6, 5'd4, 32'h66,       1'b0, 32'h88,       1'b0, 6'd1};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  5'd6, 5'd7, 32'h66,       1'b0, 32'h0,        1'b0, 6'd0};

    // Reset state, with a write presented that must not be forwarded.
    RESET = 1'b1;
    drive(1'b1, 5'd5, 32'hCAFEF00D, 1'b0, 5'd0, 5'd5, 5'd1);
    #3;
    check("reset_data0", 64'(bus_a.RD_DATA[DW-1:0]), 64'h0);
    check("reset_busy", 64'(bus_a.RD_BUSY), 64'h0);
    check("reset_cnt", 64'(busy_cnt), 64'h0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd1);
    #1;
    check("reset_wr_ignored", 64'(bus_a.RD_DATA[DW-1:0]), 64'h0);

    // Table-driven vectors, one clock each.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      #2;
      checkOutput(i, vecs[i]);
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    check("tap_r3", 64'(t3), 64'h12345678);
    check("tap_r0", 64'(t0), 64'h0);
    check("nb_tap_r3", 64'(nb3), 64'h12345678);

    // Bypass on vs off for a write to r7 that was never written before.
    drive(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7, 5'd0);
    #2;
    check("byp_on_r7", 64'(bus_a.RD_DATA[DW-1:0]), 64'hA5A5A5A5);
    check("byp_off_r7", 64'(bus_b.RD_DATA[DW-1:0]), 64'h0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
    #1;
    check("byp_off_r7_after", 64'(bus_b.RD_DATA[DW-1:0]), 64'hA5A5A5A5);

    // Without bypass the write cycle shows the old busy flag and old data.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 5'd10, 5'd0);
    tick();
    drive(1'b1, 5'd10, 32'hAB, 1'b0, 5'd0, 5'd10, 5'd0);
    #2;
    check("byp_on_r10_busy", 64'(bus_a.RD_BUSY[0]), 64'h0);
    check("byp_on_r10_data", 64'(bus_a.RD_DATA[DW-1:0]), 64'hAB);
    check("byp_off_r10_busy", 64'(bus_b.RD_BUSY[0]), 64'h1);
    check("byp_off_r10_data", 64'(bus_b.RD_DATA[DW-1:0]), 64'h0);
    check("r10_cnt_before", 64'(busy_cnt), 64'h1);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd0);
    #1;
    check("r10_cnt_after", 64'(busy_cnt), 64'h0);

    // Saturation: issue every register, r0 included.
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'd0, 5'd31);
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd17, 5'd0, 5'd31);
    #1;
    check("sat_cnt", 64'(busy_cnt), 64'd31);
    check("sat_r0_busy", 64'(bus_a.RD_BUSY[0]), 64'h0);
    check("sat_r31_busy", 64'(bus_a.RD_BUSY[1]), 64'h1);
    tick();
    check("sat_reissue_cnt", 64'(busy_cnt), 64'd31);
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'(i) * 32'h01010101, 1'b0, 5'd0, 5'd0, 5'd0);
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd17, 5'd31);
    #1;
    check("drain_cnt", 64'(busy_cnt), 64'd0);
    check("drain_r17", 64'(bus_a.RD_DATA[DW-1:0]), 64'h11111111);
    check("drain_r31_busy", 64'(bus_a.RD_BUSY[1]), 64'h0);

    // Asynchronous reset asserted mid-cycle while state is non-zero.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 5'd5, 5'd2);
    tick();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd2);
    tick();
    drive(1'b1, 5'd6, 32'h12121212, 1'b0, 5'd0, 5'd5, 5'd2);
    #1;
    check("pre_rst_r5", 64'(bus_a.RD_DATA[DW-1:0]), 64'hDEADBEEF);
    check("pre_rst_cnt", 64'(busy_cnt), 64'h1);
    drive(1'b1, 5'd5, 32'h0BADF00D, 1'b1, 5'd8, 5'd5, 5'd2);
    RESET = 1'b1;
    #1;
    check("rst_r5", 64'(bus_a.RD_DATA[DW-1:0]), 64'h0);
    check("rst_busy", 64'(bus_a.RD_BUSY), 64'h0);
    check("rst_cnt", 64'(busy_cnt), 64'h0);
    check("rst_nb_cnt", 64'(busy_cnt_nb), 64'h0);
    check("rst_taps", {t0, t1} | {t2, t3}, 64'h0);
    tick();
    RESET = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd8);
    #1;
    check("rst_wr_dropped", 64'(bus_a.RD_DATA[DW-1:0]), 64'h0);
    check("rst_iss_dropped", 64'(bus_a.RD_BUSY[1]), 64'h0);
    tick();
    check("rst_cnt_after", 64'(busy_cnt), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Parametrised successor to the CPU's 32x32 register file.
- Provides NUM_READ combinational read ports, one synchronous write port, an optional hardwired zero register, optional write-to-read bypass, and a per-register busy (scoreboard) bit for pipeline hazard detection.
- Sits between decode (read and issue) and writeback (write).
- Keeps four debug taps for the existing test bench.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_READ, 2, number of independent read ports (1..4).
- ZERO_REG, 1, when 1 register 0 always reads 0 and is never busy.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- RD_ADDR  in  NUM_READ*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- RD_DATA  out  NUM_READ*DATA_W  packed read data, same packing.
- RD_BUSY  out  NUM_READ  per-port busy flag of the addressed register.
- WR_EN  in  1  writeback enable.
- WR_ADDR  in  ADDR_W  writeback address.
- WR_DATA  in  DATA_W  writeback data.
- ISS_EN  in  1  issue: mark ISS_ADDR as pending a result.
- ISS_ADDR  in  ADDR_W  destination register being issued.
- BUSY_CNT  out  ADDR_W+1  number of registers currently busy.
- TEST_R0..TEST_R3  out  DATA_W each  raw contents of registers 0..3 (no bypass).

Behaviour:
- Reset (async, RESET=1): all registers = 0, all busy bits = 0, BUSY_CNT = 0. Takes effect immediately, mid-operation included. While RESET is high, writes and issues are ignored. Reads during reset return 0 and RD_BUSY=0.
- Write: at the rising CLK edge with WR_EN=1, reg[WR_ADDR] <= WR_DATA and busy[WR_ADDR] <= 0. Exception: when ZERO_REG=1 and WR_ADDR=0, the write is discarded.
- Issue: at the rising CLK edge with ISS_EN=1, busy[ISS_ADDR] <= 1. Ignored for address 0 when ZERO_REG=1.
- Issue and write to the same address in the same cycle: data is written and busy ends at 1, because the newer producer wins.
- Issue and write to different addresses in the same cycle: both take effect independently.
- Writing a register that is not busy is legal; busy stays 0.
- Issuing an already-busy register is legal; busy stays 1 and BUSY_CNT is unchanged.
- Read, per port k (combinational, zero latency), evaluated in this priority order:
  1. ZERO_REG=1 and address 0: data 0, busy 0.
  2. BYPASS=1, WR_EN=1, WR_ADDR==RD_ADDR[k] (and not the zero-register case): data = WR_DATA, busy 0.
  3. Otherwise: data = reg[addr], busy = busy[addr].
- Same-cycle ISS_EN does not affect RD_BUSY; the effect is visible from the next cycle.
- With BYPASS=0, a read in the write cycle returns the old value and the old busy flag.
- BUSY_CNT is a registered count, updated each edge by +1, -1 or 0 according to the net change in the busy vector. It never exceeds 2**ADDR_W (or 2**ADDR_W-1 when ZERO_REG=1). It must equal the popcount of the busy vector at all times.
- TEST_Rn return stored contents: register 0 reads its stored value, which stays 0 when ZERO_REG=1.
- No X propagation: every out-of-range port index is prohibited by parameter check (NUM_READ 1..4).

Decomposition:
- Shared package rf_pkg holds:
  - DATA_W and ADDR_W defaults shared with the ALU and CPU top.
  - Constant ZERO_ADDR = 0.
  - Function for packed-port slicing.
- Natural sub-module: rf_read_port (one instance per read port, generated NUM_READ times). It implements the zero/bypass/array priority mux for a single address and yields data and busy.
- Storage array, busy vector and counter stay in the top.

Test Plan:
- Reset check: write 0xDEADBEEF to r5, assert RESET asynchronously mid-cycle -> RD_DATA(r5)=0 immediately; BUSY_CNT=0; TEST_R0..3=0.
- Write/read and zero register: write 0x12345678 to r3, then 0xFFFFFFFF to r0 -> port0(r3)=0x12345678, TEST_R3=0x12345678, port1(r0)=0, TEST_R0=0.
- Bypass: in the same cycle WR_EN=1, WR_ADDR=7, WR_DATA=0xA5A5A5A5, RD_ADDR port0=7 -> RD_DATA port0=0xA5A5A5A5 before the edge. With BYPASS=0, port0 returns the old 0 instead.
- Scoreboard: issue r9 -> next cycle RD_BUSY(r9)=1 and BUSY_CNT=1. Write r9=0x55 -> RD_BUSY=0 in that same cycle via bypass, BUSY_CNT=0 after the edge.
- Simultaneous events: with r4 busy, ISS r4 and WR r4=0x77 in the same cycle -> r4=0x77, busy=1, BUSY_CNT stays 1. Then ISS r6 and WR r4 -> busy r6=1, r4=0, BUSY_CNT=1.
- Saturation: issue all 31 non-zero registers (ZERO_REG=1) plus r0 -> BUSY_CNT=31; r0 not busy; writing all back returns BUSY_CNT to 0.
